spi_ram_ctrl: RTL and testbench
===============================

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, the number of 8-bit memory words.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, the address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, 10 bits: the command frame from the SPI slave; [9:8] is the opcode and [7:0] is the payload.
REQ-006 SHALL have port rx_valid, input, 1 bit: when high, rx_data is a complete frame to consume this cycle.
REQ-007 SHALL have port tx_data, output, 8 bits: read data returned to the SPI slave for MISO shifting.
REQ-008 SHALL have port tx_valid, output, 1 bit: when high, tx_data is valid and stable.

Function
REQ-009 SHALL contain an internal array mem of MEM_DEPTH x 8 bits, with a write-address register wr_addr and a read-address register rd_addr, each ADDR_SIZE bits.
REQ-010 SHALL decode rx_data[9:8] only on a clock edge where rx_valid=1; with rx_valid=0 there is no state change, and tx_data/tx_valid hold.
REQ-011 Opcode 00 (WR_ADDR) SHALL set wr_addr to rx_data[ADDR_SIZE-1:0].
REQ-012 Opcode 01 (WR_DATA) SHALL set mem[wr_addr] to rx_data[7:0], then wr_addr to wr_addr+1, modulo MEM_DEPTH (MEM_DEPTH-1 wraps to 0).
REQ-013 Opcode 10 (RD_ADDR) SHALL set rd_addr to rx_data[ADDR_SIZE-1:0].
REQ-014 Opcode 11 (RD_DATA) SHALL set tx_data to mem[rd_addr] and tx_valid to 1 on the same edge (1-cycle latency), then rd_addr to rd_addr+1, modulo MEM_DEPTH.
REQ-015 tx_valid SHALL stay high after RD_DATA until the next edge with rx_valid=1 and opcode other than 11, at which edge it SHALL go low.
REQ-016 A back-to-back RD_DATA (rx_valid=1, opcode 11) while tx_valid=1 SHALL reload tx_data from the new rd_addr and keep tx_valid high.
REQ-017 tx_data SHALL change only on an RD_DATA edge or on reset.
REQ-018 The control state machine SHALL have two states:
- IDLE: tx_valid=0.
- RESP: tx_valid=1.
- IDLE to RESP on RD_DATA.
- RESP to RESP on RD_DATA.
- RESP to IDLE on any other accepted opcode.
- Otherwise the state holds.
REQ-019 A WR_DATA to an address followed by RD_ADDR/RD_DATA to that address SHALL return the newly written byte (no stale read).
REQ-020 wr_addr and rd_addr SHALL be independent; write commands SHALL NOT modify rd_addr, and read commands SHALL NOT modify wr_addr.
REQ-021 rx_valid held high on consecutive cycles SHALL be treated as consecutive, independent commands, one per cycle.

Reset
REQ-022 On rst_n=0, regardless of clk, the block SHALL immediately force tx_data=8'h00, tx_valid=0, wr_addr=0, rd_addr=0 and state=IDLE.
REQ-023 Memory contents SHALL NOT be reset, and SHALL NOT be written while rst_n=0.
REQ-024 A reset asserted while tx_valid=1 SHALL drop tx_valid asynchronously, and the pending response SHALL be discarded.
REQ-025 The first rising clk edge after rst_n deasserts SHALL process rx_valid normally.

Verification
REQ-026 The bench SHALL check: WR_ADDR 0x12, then WR_DATA 0xA5, then RD_ADDR 0x12, then RD_DATA -> tx_data=0xA5 and tx_valid=1 one edge after the RD_DATA frame.
REQ-027 The bench SHALL check: WR_ADDR 0xFF, then WR_DATA 0x11, then WR_DATA 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22 (wrap); reads of 0xFF then auto-increment return 0x11 then 0x22.
REQ-028 The bench SHALL check: RD_DATA with tx_valid=1, then rx_valid=0 for 20 cycles -> tx_valid stays 1 and tx_data stays constant; a following WR_ADDR frame -> tx_valid=0 on that edge.
REQ-029 The bench SHALL check: rst_n pulsed low mid-cycle while tx_valid=1 -> tx_valid=0 and tx_data=0x00 before the next clk edge; previously written mem data still reads back after reset.
REQ-030 The bench SHALL check: rx_valid held high for 4 cycles carrying WR_ADDR 0x05, WR_DATA 0x3C, RD_ADDR 0x05, RD_DATA -> tx_data=0x3C with tx_valid=1 one edge after the fourth frame.
REQ-031 The bench SHALL check: a frame with rx_valid=0 and opcode 01 -> no memory write and no change to wr_addr.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// Command decoder and byte-wide RAM behind an SPI slave: 10-bit frames carry a
// 2-bit opcode that sets write/read pointers, stores a byte, or returns a byte.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  state_t               state;
  state_t               state_next;

  logic [1:0]           opcode;
  logic [7:0]           payload;
  logic                 cmd_wr_addr;
  logic                 cmd_wr_data;
  logic                 cmd_rd_addr;
  logic                 cmd_rd_data;

  assign opcode  = rx_data[9:8];
  assign payload = rx_data[7:0];

  // Opcodes are only meaningful when the frame is marked valid.
  always_comb begin
    cmd_wr_addr = 1'b0;
    cmd_wr_data = 1'b0;
    cmd_rd_addr = 1'b0;
    cmd_rd_data = 1'b0;
    if (rx_valid) begin
      case (opcode)
        OP_WR_ADDR: cmd_wr_addr = 1'b1;
        OP_WR_DATA: cmd_wr_data = 1'b1;
        OP_RD_ADDR: cmd_rd_addr = 1'b1;
        default:    cmd_rd_data = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_rd_data) begin
          state_next = RESP;
        end
      end
      RESP: begin
        tx_valid = 1'b1;
        if (rx_valid && !cmd_rd_data) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointers wrap naturally because they are exactly ADDR_SIZE bits wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
    end else if (cmd_wr_addr) begin
      wr_addr <= payload[ADDR_SIZE-1:0];
    end else if (cmd_wr_data) begin
      wr_addr <= wr_addr + ADDR_SIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
    end else if (cmd_rd_addr) begin
      rd_addr <= payload[ADDR_SIZE-1:0];
    end else if (cmd_rd_data) begin
      rd_addr <= rd_addr + ADDR_SIZE'(1);
    end
  end

  // Storage is never cleared; the rst_n gate keeps frames seen during reset out.
  always_ff @(posedge clk) begin
    if (rst_n && cmd_wr_data) begin
      mem[wr_addr] <= payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= 8'h00;
    end else if (cmd_rd_data) begin
      tx_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: a reference memory/pointer model feeds
// an expected-read queue that is popped one edge after each RD_DATA frame.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_mem [256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  logic [7:0] m_tx;
  logic       m_valid;
  logic [7:0] exp_q [$];

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one valid frame, advance the model, then check one edge later.
  task automatic send(input string tag, input logic [1:0] op, input logic [7:0] pl);
    logic [7:0] exp_byte;
    rx_valid = 1'b1;
    rx_data  = {op, pl};
    case (op)
      2'b00: m_wr = pl;
      2'b01: begin m_mem[m_wr] = pl; m_wr = m_wr + 8'd1; end
      2'b10: m_rd = pl;
      default: begin exp_q.push_back(m_mem[m_rd]); m_rd = m_rd + 8'd1; end
    endcase
    @(posedge clk);
    #1;
    if (op == 2'b11) begin
      exp_byte = exp_q.pop_front();
      m_tx     = exp_byte;
      m_valid  = 1'b1;
    end else begin
      m_valid  = 1'b0;
    end
    check({tag, ".tx_valid"}, {31'd0, tx_valid}, {31'd0, m_valid});
    check({tag, ".tx_data"}, {24'd0, tx_data}, {24'd0, m_tx});
    $display("txn %s op=%0d payload=0x%02h tx_valid=%0b tx_data=0x%02h", tag, op, pl, tx_valid, tx_data);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    m_wr = 8'h00; m_rd = 8'h00; m_tx = 8'h00; m_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset.tx_data", {24'd0, tx_data}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read-back
    send("basic_wa", 2'b00, 8'h12);
    send("basic_wd", 2'b01, 8'hA5);
    send("basic_ra", 2'b10, 8'h12);
    send("basic_rd", 2'b11, 8'h00);
    idle(1);

    // Pointer wrap at the top of memory, back-to-back reads
    send("wrap_wa", 2'b00, 8'hFF);
    send("wrap_wd0", 2'b01, 8'h11);
    send("wrap_wd1", 2'b01, 8'h22);
    send("wrap_ra", 2'b10, 8'hFF);
    send("wrap_rd0", 2'b11, 8'h00);
    send("wrap_rd1", 2'b11, 8'h00);
    check("wrap_model0", {24'd0, m_tx}, 32'h22);

    // Response held while idle, dropped by the next non-read frame
    idle(20);
    check("hold.tx_valid", {31'd0, tx_valid}, 32'd1);
    check("hold.tx_data", {24'd0, tx_data}, 32'h22);
    send("hold_drop", 2'b00, 8'h30);

    // Async reset mid-cycle during an active response
    send("rst_ra", 2'b10, 8'h12);
    send("rst_rd", 2'b11, 8'h00);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = {2'b01, 8'hEE};
    #1;
    check("rst_async.tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_async.tx_data", {24'd0, tx_data}, 32'h00);
    @(posedge clk);
    #1;
    check("rst_held.tx_valid", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    m_wr = 8'h00; m_rd = 8'h00; m_tx = 8'h00; m_valid = 1'b0;
    send("post_rst_rd0", 2'b11, 8'h00);
    send("post_rst_ra", 2'b10, 8'h12);
    send("post_rst_rd", 2'b11, 8'h00);
    idle(1);

    // Four consecutive frames with rx_valid never dropping
    send("b2b_wa", 2'b00, 8'h05);
    send("b2b_wd", 2'b01, 8'h3C);
    send("b2b_ra", 2'b10, 8'h05);
    send("b2b_rd", 2'b11, 8'h00);
    idle(1);

    // Invalid frame must neither write memory nor move wr_addr
    send("inv_wa", 2'b00, 8'h40);
    send("inv_wd", 2'b01, 8'h77);
    rx_valid = 1'b0;
    rx_data  = {2'b01, 8'h99};
    idle(1);
    send("inv_wd2", 2'b01, 8'h88);

    // Pointer independence: write traffic between read setup and reads
    send("ind_ra", 2'b10, 8'h40);
    send("ind_wa", 2'b00, 8'h10);
    send("ind_wd", 2'b01, 8'h55);
    send("ind_rd0", 2'b11, 8'h00);
    send("ind_rd1", 2'b11, 8'h00);
    send("ind_ra2", 2'b10, 8'h10);
    send("ind_rd2", 2'b11, 8'h00);
    idle(2);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
